// File: rtl/squarewave_meter_pkg.sv
// Shared constants for squarewave_meter: FSM encoding, generator-compatible
// defaults and the per-phase flag payload.
package squarewave_meter_pkg;

  localparam int unsigned DEF_UNIT_TICKS  = 5;
  localparam int unsigned DEF_CNT_W       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  typedef struct packed {
    logic frac;
    logic ovf;
  } phase_flags_t;

endpackage

// File: rtl/squarewave_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level plus one edge-detect
// flop; rise_c/fall_c are single-cycle pulses decoded from the flop pair.
module squarewave_meter_sync_edge_detect
  import squarewave_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/squarewave_meter.sv
// Measures high/low phase lengths of a square wave in generator time units
// and reports them once per completed period.
module squarewave_meter
  import squarewave_meter_pkg::*;
#(
  parameter int unsigned UNIT_TICKS  = DEF_UNIT_TICKS,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned STUCK_UNITS = 32,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             w,
  output logic [CNT_W-1:0] meas_up,
  output logic [CNT_W-1:0] meas_down,
  output logic             meas_valid,
  output logic             meas_frac,
  output logic             meas_ovf,
  output logic             locked,
  output logic             stuck
);

  localparam int unsigned TICK_W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam int unsigned UNIT_W = $clog2(STUCK_UNITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(UNIT_TICKS - 1);
  localparam logic [UNIT_W-1:0] UNIT_STUCK = UNIT_W'(STUCK_UNITS);
  localparam logic [UNIT_W-1:0] UNIT_SAT   = UNIT_W'((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  logic rise_c;
  logic fall_c;
  logic edge_c;

  squarewave_meter_sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (w),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign edge_c = rise_c | fall_c;

  // Phase length counters; the incremented value includes the current cycle
  // so a phase seen at an edge is measured without an off-by-one.
  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_inc;
  logic [UNIT_W-1:0] unit_q;
  logic [UNIT_W-1:0] unit_inc;

  always_comb begin
    tick_inc = tick_q + TICK_W'(1);
    unit_inc = unit_q;
    if (tick_q == TICK_LAST) begin
      tick_inc = '0;
      if (unit_q != UNIT_STUCK) begin
        unit_inc = unit_q + UNIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
      unit_q <= '0;
    end else if (edge_c) begin
      tick_q <= '0;
      unit_q <= '0;
    end else begin
      tick_q <= tick_inc;
      unit_q <= unit_inc;
    end
  end

  // Saturated value and flags of the phase ending at this edge.
  logic [CNT_W-1:0] phase_units;
  phase_flags_t     phase_flags;
  logic             stuck_hit;

  always_comb begin
    phase_flags.ovf  = (unit_inc > UNIT_SAT);
    phase_flags.frac = (tick_inc != '0);
    phase_units      = phase_flags.ovf ? CNT_MAX : CNT_W'(unit_inc);
    stuck_hit        = (unit_inc == UNIT_STUCK) && !edge_c;
  end

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] hold_up_q;
  logic [CNT_W-1:0] hold_up_nxt;
  phase_flags_t     hold_flags_q;
  phase_flags_t     hold_flags_nxt;
  logic [CNT_W-1:0] meas_up_nxt;
  logic [CNT_W-1:0] meas_down_nxt;
  logic             meas_valid_nxt;
  logic             meas_frac_nxt;
  logic             meas_ovf_nxt;
  logic             locked_nxt;
  logic             stuck_nxt;

  always_comb begin
    state_nxt      = state_q;
    hold_up_nxt    = hold_up_q;
    hold_flags_nxt = hold_flags_q;
    meas_up_nxt    = meas_up;
    meas_down_nxt  = meas_down;
    meas_valid_nxt = 1'b0;
    meas_frac_nxt  = meas_frac;
    meas_ovf_nxt   = meas_ovf;
    locked_nxt     = locked;
    stuck_nxt      = stuck;

    case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_nxt = ST_HIGH;
          stuck_nxt = 1'b0;
        end
      end
      ST_HIGH: begin
        if (fall_c) begin
          hold_up_nxt    = phase_units;
          hold_flags_nxt = phase_flags;
          state_nxt      = ST_LOW;
        end else if (stuck_hit) begin
          stuck_nxt  = 1'b1;
          locked_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (rise_c) begin
          meas_up_nxt    = hold_up_q;
          meas_down_nxt  = phase_units;
          meas_frac_nxt  = hold_flags_q.frac | phase_flags.frac;
          meas_ovf_nxt   = hold_flags_q.ovf | phase_flags.ovf;
          meas_valid_nxt = 1'b1;
          locked_nxt     = 1'b1;
          state_nxt      = ST_HIGH;
        end else if (stuck_hit) begin
          stuck_nxt  = 1'b1;
          locked_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      hold_up_q    <= '0;
      hold_flags_q <= '0;
      meas_up      <= '0;
      meas_down    <= '0;
      meas_valid   <= 1'b0;
      meas_frac    <= 1'b0;
      meas_ovf     <= 1'b0;
      locked       <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      hold_up_q    <= hold_up_nxt;
      hold_flags_q <= hold_flags_nxt;
      meas_up      <= meas_up_nxt;
      meas_down    <= meas_down_nxt;
      meas_valid   <= meas_valid_nxt;
      meas_frac    <= meas_frac_nxt;
      meas_ovf     <= meas_ovf_nxt;
      locked       <= locked_nxt;
      stuck        <= stuck_nxt;
    end
  end

endmodule

// File: tb/tb_squarewave_meter.sv
// Self-checking bench for squarewave_meter: directed and random periods
// compared against an arithmetic model of the expected measurements.
module tb_squarewave_meter;

  localparam int UNIT_TICKS  = 5;
  localparam int CNT_W       = 4;
  localparam int STUCK_UNITS = 32;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             w = 1'b0;
  logic [CNT_W-1:0] meas_up;
  logic [CNT_W-1:0] meas_down;
  logic             meas_valid;
  logic             meas_frac;
  logic             meas_ovf;
  logic             locked;
  logic             stuck;

  squarewave_meter #(
    .UNIT_TICKS (UNIT_TICKS),
    .CNT_W      (CNT_W),
    .STUCK_UNITS(STUCK_UNITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .w         (w),
    .meas_up   (meas_up),
    .meas_down (meas_down),
    .meas_valid(meas_valid),
    .meas_frac (meas_frac),
    .meas_ovf  (meas_ovf),
    .locked    (locked),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    int up;
    int down;
    int frac;
    int ovf;
    int cyc;
  } obs_t;

  typedef struct {
    int h;
    int l;
  } per_t;

  obs_t obs_q[$];
  per_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   carry = 0;
  int   last_up = 0;

  // Record every reported measurement with its cycle stamp.
  always @(negedge clk) begin
    obs_t o;
    cyc = cyc + 1;
    if (meas_valid === 1'b1) begin
      o.up   = int'(meas_up);
      o.down = int'(meas_down);
      o.frac = int'(meas_frac);
      o.ovf  = int'(meas_ovf);
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
  end

  task automatic check(input string tag, input int idx, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, observed, expected);
    end
  endtask

  function automatic int sat_units(input int cycles);
    return (cycles / UNIT_TICKS > CNT_MAX) ? CNT_MAX : cycles / UNIT_TICKS;
  endfunction

  // High for h cycles (some possibly already spent), low for l cycles.
  task automatic drive_period(input int h, input int l);
    per_t p;
    w = 1'b1;
    repeat (h - carry) @(negedge clk);
    carry = 0;
    w = 1'b0;
    repeat (l) @(negedge clk);
    p.h = h;
    p.l = l;
    exp_q.push_back(p);
  endtask

  // Close the last period with a rise, let results settle, then compare.
  task automatic flush_and_compare(input string tag);
    int n;
    w = 1'b1;
    repeat (10) @(negedge clk);
    carry = 10;
    check({tag, "_count"}, 0, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      int h = exp_q[i].h;
      int l = exp_q[i].l;
      check({tag, "_up"},   i, obs_q[i].up,   sat_units(h));
      check({tag, "_down"}, i, obs_q[i].down, sat_units(l));
      check({tag, "_frac"}, i, obs_q[i].frac,
            ((h % UNIT_TICKS) != 0 || (l % UNIT_TICKS) != 0) ? 1 : 0);
      check({tag, "_ovf"},  i, obs_q[i].ovf,
            (h / UNIT_TICKS > CNT_MAX || l / UNIT_TICKS > CNT_MAX) ? 1 : 0);
      if (i > 0) check({tag, "_gap"}, i, obs_q[i].cyc - obs_q[i-1].cyc, h + l);
    end
    if (n > 0) last_up = sat_units(exp_q[n-1].h);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_up"},     0, int'(meas_up),    0);
    check({tag, "_down"},   0, int'(meas_down),  0);
    check({tag, "_valid"},  0, int'(meas_valid), 0);
    check({tag, "_frac"},   0, int'(meas_frac),  0);
    check({tag, "_ovf"},    0, int'(meas_ovf),   0);
    check({tag, "_locked"}, 0, int'(locked),     0);
    check({tag, "_stuck"},  0, int'(stuck),      0);
  endtask

  initial begin
    reset_n = 1'b0;
    w = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_locked", 0, int'(locked), 0);

    // Generator m=1,n=1
    repeat (4) drive_period(5, 5);
    flush_and_compare("m1n1");
    check("m1n1_locked", 0, int'(locked), 1);

    // Generator m=5,n=1 then m=1,n=5
    repeat (3) drive_period(25, 5);
    repeat (3) drive_period(5, 25);
    flush_and_compare("m5n1_m1n5");

    // Direct fractional, overflow and minimum-width phases
    drive_period(12, 3);
    drive_period(3, 12);
    drive_period(100, 5);
    drive_period(1, 1);
    drive_period(1, 1);
    drive_period(2, 1);
    drive_period(4, 6);
    flush_and_compare("direct");

    // Random phases, kept below the stuck threshold
    drive_period(20, 20);
    for (int i = 0; i < 12; i++) begin
      drive_period(int'($urandom_range(1, 150)), int'($urandom_range(1, 150)));
    end
    flush_and_compare("rand");

    // Stuck low
    carry = 0;
    w = 1'b0;
    repeat (170) @(negedge clk);
    check("stuck_set",    0, int'(stuck),  1);
    check("stuck_locked", 0, int'(locked), 0);
    check("stuck_nvalid", 0, obs_q.size(), 0);
    check("stuck_hold",   0, int'(meas_up), last_up);
    w = 1'b1;
    repeat (6) @(negedge clk);
    carry = 6;
    check("unstuck",        0, int'(stuck),  0);
    check("unstuck_locked", 0, int'(locked), 0);
    check("unstuck_nvalid", 0, obs_q.size(), 0);
    drive_period(20, 10);
    drive_period(5, 5);
    flush_and_compare("post_stuck");
    check("post_stuck_locked", 0, int'(locked), 1);

    // Reset in the middle of a high phase
    reset_n = 1'b0;
    w = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    carry = 0;
    check("rel_nvalid", 0, obs_q.size(), 0);
    check("rel_locked", 0, int'(locked), 0);
    drive_period(7, 8);
    drive_period(1, 1);
    drive_period(10, 3);
    flush_and_compare("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/squarewave_meter.md
Name: squarewave_meter

Overview:
Downstream consumer of squarewave_generator: samples its output w and measures the length of each high and low phase in generator time units. Reports the measured up/down times per completed period with a one-cycle valid strobe, plus fraction, overflow and stuck-line flags. Used as an in-system self-check of the generator's m/n programming and as a general pulse-width monitor.

Parameters:
UNIT_TICKS, 5, clk cycles per generator time unit (100 ns at 50 MHz); must be >= 1
CNT_W, 4, width of reported up/down counts (matches generator m/n width)
STUCK_UNITS, 32, phase length in units at which the line is declared stuck; must exceed 2^CNT_W-1
SYNC_STAGES, 2, flops in the input synchronizer; must be >= 2

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
w  input  1  square wave under measurement (treated as asynchronous)
meas_up  output  CNT_W  high-phase length of last completed period, units
meas_down  output  CNT_W  low-phase length of last completed period, units
meas_valid  output  1  one-cycle strobe: meas_* updated this cycle
meas_frac  output  1  either phase of last period was not a whole multiple of UNIT_TICKS
meas_ovf  output  1  either phase of last period exceeded 2^CNT_W-1 units (value saturated)
locked  output  1  at least one valid period measured since reset/stuck
stuck  output  1  line has held one level for STUCK_UNITS units

Behaviour:
- Reset (async assert, sync-release irrelevant inside block): all outputs 0, synchronizer flops 0, state IDLE, counters 0.
- Input path: w passes SYNC_STAGES flops, then one edge-detect flop; rise/fall pulses are single-cycle. Fixed latency SYNC_STAGES+1 cycles; does not affect measured lengths.
- Phase length counted in clk cycles between consecutive synchronized edges: tick counter 0..UNIT_TICKS-1, unit counter increments on tick wrap, saturating at STUCK_UNITS. Both cleared on every edge.
- Reported value = floor(ticks/UNIT_TICKS), saturated to 2^CNT_W-1; ovf set if saturation applied; frac set if tick counter nonzero at edge. Zero units legal (phase shorter than UNIT_TICKS -> 0 with frac=1).
- FSM states: IDLE, HIGH, LOW.
  IDLE: ignore levels; on rise -> HIGH (first partial phase discarded).
  HIGH: on fall -> latch up-count/flags into holding regs, -> LOW.
  LOW: on rise -> drive meas_up from holding, meas_down from current count, frac/ovf = OR of both phases, meas_valid=1 for that cycle, locked=1, -> HIGH.
  HIGH or LOW: unit counter reaches STUCK_UNITS -> stuck=1, locked=0, -> IDLE; no meas_valid.
- stuck clears on the next synchronized rise (same cycle IDLE -> HIGH). meas_* hold last values until next meas_valid.
- meas_valid never asserts twice within fewer than 2 cycles; back-to-back periods of 1 cycle each phase are measured correctly (0 units, frac=1 when UNIT_TICKS>1).
- Reset mid-operation: everything returns to reset values immediately; first valid only after a full new period following a fresh rise.

Decomposition:
- Shared package: FSM state encoding (IDLE/HIGH/LOW), default UNIT_TICKS and CNT_W constants shared with squarewave_generator.
- One sub-module: sync_edge_detect (SYNC_STAGES synchronizer + rise/fall pulse outputs, async active-low reset). Counters and FSM stay in top.

Test Plan:
- Generator m=1,n=1, UNIT_TICKS=5 -> after first full period meas_up=1, meas_down=1, frac=0, ovf=0, meas_valid every 10 clk, locked=1.
- Generator m=5,n=1 -> meas_up=5, meas_down=1, meas_valid every 30 clk; switching to m=1,n=5 mid-run -> first post-switch period may differ, then up=1, down=5.
- Direct drive: high 3 clk, low 12 clk -> meas_up=0, meas_down=2, frac=1.
- Direct drive: high 100 clk (20 units), low 5 clk -> meas_up=15, meas_down=1, ovf=1.
- Hold w low 160 clk (32 units) after lock -> stuck=1, locked=0, no valid; next rise clears stuck, valid only after following full period.
- Assert reset_n=0 mid-HIGH phase -> all outputs 0 same cycle; after release first meas_valid only after rise, fall, rise sequence.
